// File: rtl/isa_shared_pkg.sv
// Shared types for the core's memory path: arbiter FSM state and transaction owner.
package isa_shared;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_IFETCH,
        OWNER_DATA
    } arb_owner_t;

    localparam int ARB_CTR_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants made while fetch waits; flags when fetch must win.
module arb_starve_ctr
    import isa_shared::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_force
);

    localparam logic [ARB_CTR_W-1:0] LIMIT = STARVE_LIMIT[ARB_CTR_W-1:0];

    logic [ARB_CTR_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_force = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store traffic onto one single-ported memory.
// Define MEM_ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT back-to-back data grants.
module mem_arbiter
    import isa_shared::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [DATA_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be 1..15");
    end

    arb_state_t r_state;
    arb_owner_t r_owner;
    logic       r_we;
    logic       w_idle;
    logic       w_force_i;
    logic       w_pick_d;

    assign w_idle = (r_state == ARB_IDLE) && !rst;

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (d_gnt && i_req),
        .i_clr   (w_idle && (!i_req || i_gnt)),
        .o_force (w_force_i)
    );
`else
    assign w_force_i = 1'b0;
`endif

    assign w_pick_d = d_req && !(i_req && w_force_i);
    assign d_gnt    = w_idle && w_pick_d;
    assign i_gnt    = w_idle && i_req && !w_pick_d;

    // Strobes and the write enable default low every cycle; only mem_addr/mem_wdata hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= OWNER_IFETCH;
            r_we      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_write <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (d_gnt) begin
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_write <= d_we;
                        r_we      <= d_we;
                        r_owner   <= OWNER_DATA;
                        r_state   <= ARB_ACCESS;
                    end else if (i_gnt) begin
                        mem_addr  <= i_addr;
                        r_we      <= 1'b0;
                        r_owner   <= OWNER_IFETCH;
                        r_state   <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    r_state <= r_we ? ARB_IDLE : ARB_RESP;
                end
                ARB_RESP: begin
                    if (r_owner == OWNER_DATA) begin
                        d_rdata  <= mem_rdata;
                        d_rvalid <= 1'b1;
                    end else begin
                        i_rdata  <= mem_rdata;
                        i_rvalid <= 1'b1;
                    end
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single transactions plus arbitration/reset sequences.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam logic [1:0] K_F = 2'd0, K_L = 2'd1, K_S = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [DW-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic          i_gnt, d_gnt, i_rvalid, d_rvalid, mem_write;
    logic [DW-1:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    // Memory model: registered read, preloaded while rst is high.
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 64; k++) mem[k] <= '0;
            mem[1]    <= 32'h0000_0413;
            mem[4]    <= 32'h0050_0093;
            mem[8]    <= 32'hA5A5_0020;
            mem_rdata <= '0;
        end else begin
            if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    typedef struct {
        logic          port;   // 1 = data port
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sbq[$];

    task automatic push_exp(input logic port, input logic [DW-1:0] data, input int at);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    // Response monitor: every rvalid must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (i_rvalid === 1'b1 || d_rvalid === 1'b1) begin
            if (i_rvalid && d_rvalid) fail("dual_rvalid");
            if (sbq.size() == 0) begin
                fail("unexpected_rvalid");
            end else begin
                e = sbq.pop_front();
                check("rv_port", {31'b0, d_rvalid}, {31'b0, e.port});
                check("rv_data", d_rvalid ? d_rdata : i_rdata, e.data);
                check("rv_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_gnt(input logic is_d, output int t, output logic ok);
        ok = 1'b0;
        t  = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (is_d ? d_gnt : i_gnt) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        if (!ok) fail("gnt_timeout");
    endtask

    task automatic drop_reqs();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '1; d_addr = '1; d_wdata = '0;
    endtask

    typedef struct {
        logic [1:0]    kind;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        int   t;
        logic ok;
        @(posedge clk); #1;
        if (v.kind == K_F) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = (v.kind == K_S); d_addr = v.addr; d_wdata = v.wdata;
        end
        wait_gnt(v.kind != K_F, t, ok);
        if (ok) begin
            if (v.kind != K_S) push_exp(v.kind != K_F, v.exp, t + 3);
            @(posedge clk); #1;
            drop_reqs();
            @(negedge clk);
            check("acc_addr", mem_addr, v.addr);
            check("acc_we", {31'b0, mem_write}, {31'b0, v.kind == K_S});
            if (v.kind == K_S) check("acc_wdata", mem_wdata, v.wdata);
            @(negedge clk);
            check("post_we", {31'b0, mem_write}, 32'd0);
        end
        repeat (4) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int         t, td, ti, prev;
        logic       ok;
        logic [5:0] exp_order;

        vecs[0] = '{K_F, 32'h10, 32'h0,         32'h0050_0093};
        vecs[1] = '{K_S, 32'h40, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{K_L, 32'h40, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{K_F, 32'h40, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{K_S, 32'h44, 32'h1234_5678, 32'h0};
        vecs[5] = '{K_L, 32'h44, 32'h0,         32'h1234_5678};
        vecs[6] = '{K_L, 32'h10, 32'h0,         32'h0050_0093};
        vecs[7] = '{K_F, 32'h00, 32'h0,         32'h0};

        // Reset: grants masked even with a request present.
        d_req = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dgnt", {31'b0, d_gnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Simultaneous requests: data first, fetch granted the cycle data's rvalid is high.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        i_req = 1'b1; i_addr = 32'h04;
        @(negedge clk);
        check("both_dgnt", {31'b0, d_gnt}, 32'd1);
        check("both_ignt", {31'b0, i_gnt}, 32'd0);
        td = cyc;
        push_exp(1'b1, 32'hA5A5_0020, td + 3);
        @(posedge clk); #1;
        d_req = 1'b0;
        wait_gnt(1'b0, ti, ok);
        if (ok) begin
            check("ifetch_gnt_cycle", ti, td + 3);
            push_exp(1'b0, 32'h0000_0413, ti + 3);
        end
        @(posedge clk); #1;
        drop_reqs();
        repeat (6) @(negedge clk);
        check("both_drained", sbq.size(), 0);

        // Both held high: grant order shows the arbitration policy.
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_order = 6'b011011;
`else
        exp_order = 6'b111111;
`endif
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        i_req = 1'b1; i_addr = 32'h04;
        prev = 0;
        for (int g = 0; g < 6; g++) begin
            ok = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (d_gnt || i_gnt) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                fail("order_timeout");
                break;
            end
            check($sformatf("order_%0d", g), {31'b0, d_gnt}, {31'b0, exp_order[g]});
            if (g > 0) check($sformatf("order_gap_%0d", g), cyc, prev + 3);
            prev = cyc;
            push_exp(d_gnt, d_gnt ? 32'hA5A5_0020 : 32'h0000_0413, cyc + 3);
        end
        @(posedge clk); #1;
        drop_reqs();
        repeat (6) @(negedge clk);
        check("order_drained", sbq.size(), 0);

        // Reset during ACCESS of a load: the load is dropped, no late rvalid.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        wait_gnt(1'b1, t, ok);
        @(posedge clk); #1;
        d_req = 1'b0;
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        check("rst_acc_ignt", {31'b0, i_gnt}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_idle_ignt", {31'b0, i_gnt}, 32'd0);
        check("rst_idle_we", {31'b0, mem_write}, 32'd0);
        check("rst_idle_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_gnt(1'b0, t, ok);
        if (ok) push_exp(1'b0, 32'h0050_0093, t + 3);
        @(posedge clk); #1;
        drop_reqs();
        @(negedge clk);
        check("post_rst_addr", mem_addr, 32'h10);
        check("post_rst_we", {31'b0, mem_write}, 32'd0);
        repeat (6) @(negedge clk);
        check("final_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported data/instruction memory between the core's instruction-fetch path and its load/store path. Requesters use a req/gnt handshake. A three-state FSM serialises one transaction at a time onto the memory port and returns read data with a registered valid strobe. The block sits between `control` and the `memory` instance, replacing the two separate memory instances once the core moves to a unified memory.

## Interface
- `DATA_WIDTH`, 32: width of addresses and data on all ports.
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits. Used only with the starvation guard; legal range 1..15.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch read request; held until `i_gnt`.
- `i_addr`  in  DATA_WIDTH  fetch byte address.
- `i_gnt`  out  1  fetch request accepted this cycle (combinational).
- `i_rvalid`  out  1  one-cycle strobe; `i_rdata` is valid.
- `i_rdata`  out  DATA_WIDTH  fetch read data.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  DATA_WIDTH  data byte address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_rvalid`  out  1  one-cycle strobe, loads only.
- `d_rdata`  out  DATA_WIDTH  load data.
- `mem_addr`  out  DATA_WIDTH  memory address (registered).
- `mem_wdata`  out  DATA_WIDTH  memory write data (registered).
- `mem_write`  out  1  memory write enable (registered).
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid one cycle after the address is presented.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - If any request is present, pick a winner and assert its gnt for exactly one cycle.
  - On the edge, latch addr, wdata, we and owner into `mem_*`, then go to ACCESS.
  - If no request is present, stay in IDLE. `mem_write` is 0.
- **Arbitration**
  - Only one requester: it wins.
  - Both requesting: data wins, unless the starvation guard forces fetch.
- **ACCESS**
  - `mem_addr` and `mem_write` are driven from the latched values.
  - Store: `mem_write`=1 for this one cycle only, then go to IDLE. No rvalid is produced.
  - Load or fetch: go to RESP.
- **RESP**
  - `mem_rdata` is sampled into the owner's rdata register.
  - On the same edge, the owner's rvalid is set for one cycle. Then go to IDLE.
- gnt is never asserted outside IDLE.
- A requester may change its addr/data after gnt. The arbiter ignores req while busy.
- `mem_addr` and `mem_wdata` hold their last value when idle. Only `mem_write` is forced to 0.
- The non-owner's rdata is unchanged. rdata holds until the next response to that port.

## Timing
- Reset values: FSM=IDLE; `mem_addr`=0, `mem_wdata`=0, `mem_write`=0; both rvalid=0, both rdata=0; starvation counter=0.
- Both gnt outputs are 0 while `rst`=1.
- Read latency, gnt cycle = T: ACCESS at T+1, RESP at T+2, rvalid high during T+3.
- The next gnt is possible in the cycle rvalid is high, because the FSM is back in IDLE at T+3.
- Read occupancy: 3 cycles per transaction.
- Store: gnt at T, `mem_write` high during T+1, next gnt possible at T+2.
- `rst` asserted in ACCESS or RESP:
  - the transaction is dropped;
  - `mem_write` and rvalid are 0 from the next edge;
  - no late rvalid is ever produced.
- `rst` has priority over every other event on the same edge.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter increments on each data grant made while `i_req`=1.
  - It clears on a fetch grant or whenever `i_req`=0 in IDLE.
  - When counter == `STARVE_LIMIT` and both requests are present, fetch wins.
  - The counter saturates and never wraps.
- `MEM_ARB_STARVE_GUARD_EN` undefined: strict data priority. The counter and `STARVE_LIMIT` logic are absent.

## Structure
- `isa_shared` gains:
  - `arb_state_t` enum: ARB_IDLE, ARB_ACCESS, ARB_RESP.
  - `arb_owner_t` enum: OWNER_IFETCH, OWNER_DATA.
- Sub-module `arb_starve_ctr`: saturating counter plus compare, instantiated only under the macro.

## Test plan
- Fetch only: `i_req` with `i_addr`=0x10, memory word 0x00500093 → `i_gnt` at T, `mem_addr`=0x10 at T+1, `i_rvalid`=1 with `i_rdata`=0x00500093 at T+3.
- Both request in the same cycle: `d_addr`=0x20 load, `i_addr`=0x04 → `d_gnt` first, `d_rvalid` at T+3, `i_gnt` at T+3, `i_rvalid` at T+6.
- Store then load: store 0xDEADBEEF to 0x40 → `mem_write`=1 for exactly one cycle. Load from 0x40 → `d_rdata`=0xDEADBEEF; `i_rvalid` stays 0.
- Guard on, `STARVE_LIMIT`=2, `d_req` and `i_req` held high → grant order D, D, I, D, D, I. Guard off → fetch is never granted while `d_req`=1.
- `rst` pulsed in ACCESS of a load → `mem_write`=0 and both rvalid=0 on every cycle after. The FSM is IDLE and the next request is granted normally.
